mem_access_unit: RTL and testbench

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mem_access_unit_pkg.sv | 21 ++
 rtl/mem_access_unit_wait_timer.sv | 40 ++++
 rtl/mem_access_unit.sv | 168 ++++++++++++++++
 tb/tb_mem_access_unit.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the memory access unit and the controller that drives it.
package mem_access_unit_pkg;

    localparam int unsigned DATA_W_DEF  = 16;
    localparam int unsigned ADDR_W_DEF  = 12;
    localparam int unsigned TIMEOUT_DEF = 15;

    // Instruction field positions within the instruction register.
    localparam int unsigned OPCODE_MSB = 15;
    localparam int unsigned OPCODE_LSB = 12;
    localparam int unsigned FUNC_MSB   = 8;
    localparam int unsigned FUNC_LSB   = 0;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DONE,
        ERR
    } mau_state_e;

endpackage

// File: rtl/mem_access_unit_wait_timer.sv
// Bus wait counter: counts cycles while enabled and flags the last permitted cycle.
module wait_timer
    import mem_access_unit_pkg::*;
#(
    parameter int unsigned LIMIT = TIMEOUT_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned CNT_W = $clog2(LIMIT + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // expired is high during the LIMIT-th enabled cycle after a clear.
    assign expired = (cnt_q == CNT_W'(LIMIT - 1));

    // Next count: clear wins, otherwise advance while enabled and saturate at the limit.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable && !expired) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Counter register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mem_access_unit.sv
// Memory access unit: turns controller read/write commands into one handshaked
// bus transaction, captures read data into IR/MDR and stalls the controller meanwhile.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int unsigned DATA_W  = DATA_W_DEF,
    parameter int unsigned ADDR_W  = ADDR_W_DEF,
    parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic              iord,
    input  logic              ir_write,
    input  logic [ADDR_W-1:0] pc,
    input  logic [ADDR_W-1:0] alu_out,
    input  logic [DATA_W-1:0] wdata,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic [DATA_W-1:0] bus_rdata,
    input  logic              bus_ack,
    output logic [DATA_W-1:0] ir,
    output logic [3:0]        opcode,
    output logic [8:0]        func,
    output logic [DATA_W-1:0] mdr,
    output logic              stall,
    output logic              bus_err
);

    mau_state_e state_q, state_d;

    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              we_q, we_d;
    logic              cap_ir_q, cap_ir_d;
    logic [DATA_W-1:0] ir_q, ir_d;
    logic [DATA_W-1:0] mdr_q, mdr_d;

    logic cmd_valid;
    logic cmd_illegal;
    logic timer_clear;
    logic timer_en;
    logic timer_expired;

    assign cmd_valid   = mem_read ^ mem_write;
    assign cmd_illegal = mem_read & mem_write;

    wait_timer #(
        .LIMIT (TIMEOUT)
    ) u_wait_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (timer_clear),
        .enable  (timer_en),
        .expired (timer_expired)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; an acknowledge in the last permitted cycle still completes.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (cmd_illegal) begin
                    state_d = ERR;
                end else if (cmd_valid) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                if (bus_ack) begin
                    state_d = DONE;
                end else if (timer_expired) begin
                    state_d = ERR;
                end
            end
            DONE:    state_d = IDLE;
            ERR:     state_d = ERR;
            default: state_d = IDLE;
        endcase
    end

    // Moore/Mealy outputs decoded from the current state.
    always_comb begin
        bus_req     = 1'b0;
        bus_we      = 1'b0;
        stall       = 1'b0;
        bus_err     = 1'b0;
        timer_clear = 1'b1;
        timer_en    = 1'b0;
        unique case (state_q)
            IDLE: stall = cmd_valid;
            REQ: begin
                bus_req     = 1'b1;
                bus_we      = we_q;
                stall       = 1'b1;
                timer_clear = 1'b0;
                timer_en    = 1'b1;
            end
            DONE: stall = 1'b0;
            ERR: begin
                stall   = 1'b1;
                bus_err = 1'b1;
            end
            default: stall = 1'b0;
        endcase
    end

    // Request latches load on command acceptance; IR/MDR load only on an acknowledged read.
    always_comb begin
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        we_d     = we_q;
        cap_ir_d = cap_ir_q;
        ir_d     = ir_q;
        mdr_d    = mdr_q;
        if (state_q == IDLE && cmd_valid) begin
            addr_d   = iord ? alu_out : pc;
            wdata_d  = wdata;
            we_d     = mem_write;
            cap_ir_d = ~iord & ir_write;
        end
        if (state_q == REQ && bus_ack && !we_q) begin
            mdr_d = bus_rdata;
            if (cap_ir_q) begin
                ir_d = bus_rdata;
            end
        end
    end

    // Datapath registers; reset overrides any same-cycle capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q   <= '0;
            wdata_q  <= '0;
            we_q     <= 1'b0;
            cap_ir_q <= 1'b0;
            ir_q     <= '0;
            mdr_q    <= '0;
        end else begin
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            we_q     <= we_d;
            cap_ir_q <= cap_ir_d;
            ir_q     <= ir_d;
            mdr_q    <= mdr_d;
        end
    end

    assign bus_addr  = addr_q;
    assign bus_wdata = wdata_q;
    assign ir        = ir_q;
    assign mdr       = mdr_q;
    assign opcode    = ir_q[OPCODE_MSB:OPCODE_LSB];
    assign func      = ir_q[FUNC_MSB:FUNC_LSB];

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed vector table, hand-written
// corner sequences, and random transactions against a transaction-level model.
module tb_mem_access_unit;

    localparam int TMO = 15;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_read = 1'b0, mem_write = 1'b0, iord = 1'b0, ir_write = 1'b0;
    logic [11:0] pc = '0, alu_out = '0;
    logic [15:0] wdata = '0;
    logic        bus_req, bus_we;
    logic [11:0] bus_addr;
    logic [15:0] bus_wdata;
    logic [15:0] bus_rdata = '0;
    logic        bus_ack = 1'b0;
    logic [15:0] ir, mdr;
    logic [3:0]  opcode;
    logic [8:0]  func;
    logic        stall, bus_err;

    int checks = 0;
    int errors = 0;

    // Model of architectural registers, updated per completed transaction.
    logic [15:0] m_ir = '0, m_mdr = '0;

    typedef struct {
        logic        rd, wr, io, irw;
        logic [11:0] pcv, aluv;
        logic [15:0] wd;
        int          delay;        // ack-free REQ cycles before ack (>= TMO: never in time)
        logic [15:0] rdata;
        int          exp_err_cyc;  // cycle index where bus_err first shows, 0 = no error
        int          exp_stall;
        int          exp_req;
        logic [15:0] exp_ir, exp_mdr;
    } vec_t;

    vec_t vecs[7];

    mem_access_unit #(
        .DATA_W  (16),
        .ADDR_W  (12),
        .TIMEOUT (TMO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .iord      (iord),
        .ir_write  (ir_write),
        .pc        (pc),
        .alu_out   (alu_out),
        .wdata     (wdata),
        .bus_req   (bus_req),
        .bus_we    (bus_we),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_rdata (bus_rdata),
        .bus_ack   (bus_ack),
        .ir        (ir),
        .opcode    (opcode),
        .func      (func),
        .mdr       (mdr),
        .stall     (stall),
        .bus_err   (bus_err)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "bench time limit exceeded");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic set_idle();
        mem_read  = 1'b0;
        mem_write = 1'b0;
        iord      = 1'b0;
        ir_write  = 1'b0;
        bus_ack   = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        set_idle();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        m_ir  = '0;
        m_mdr = '0;
    endtask

    // Drive one command, hold it until the unit releases stall, record what the bus did.
    task automatic run_txn(input vec_t t, output int stall_n, output int req_n,
                           output int err_cyc, output int bus_bad);
        logic [11:0] exp_addr;
        exp_addr = t.io ? t.aluv : t.pcv;
        stall_n = 0;
        req_n   = 0;
        err_cyc = -1;
        bus_bad = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            mem_read  = t.rd;
            mem_write = t.wr;
            iord      = t.io;
            ir_write  = t.irw;
            pc        = t.pcv;
            alu_out   = t.aluv;
            wdata     = t.wd;
            bus_ack   = (c == t.delay + 1);
            bus_rdata = (c == t.delay + 1) ? t.rdata : 16'($urandom);
            #1;
            if (stall) stall_n++;
            if (bus_req) begin
                req_n++;
                if (bus_addr !== exp_addr || bus_we !== t.wr || bus_wdata !== t.wd) bus_bad++;
            end
            if (bus_err && err_cyc < 0) err_cyc = c;
            if (!stall && c > 0 && !bus_err) break;
        end
        @(negedge clk);
        set_idle();
        #1;
    endtask

    task automatic verify(input vec_t t, input string tag);
        int stall_n, req_n, err_cyc, bus_bad;
        run_txn(t, stall_n, req_n, err_cyc, bus_bad);
        check({tag, "_req_cycles"}, req_n, t.exp_req);
        check({tag, "_bus_stable"}, bus_bad, 0);
        if (t.exp_err_cyc != 0) begin
            check({tag, "_err_cycle"}, err_cyc, t.exp_err_cyc);
            check({tag, "_err_sticky"}, bus_err, 1);
            check({tag, "_stall_sticky"}, stall, 1);
            do_reset();
            #1;
            check({tag, "_err_cleared"}, bus_err, 0);
            check({tag, "_stall_cleared"}, stall, 0);
        end else begin
            check({tag, "_no_err"}, 32'(err_cyc < 0), 1);
            check({tag, "_stall_cycles"}, stall_n, t.exp_stall);
        end
        check({tag, "_ir"}, ir, t.exp_ir);
        check({tag, "_mdr"}, mdr, t.exp_mdr);
        check({tag, "_opcode"}, opcode, t.exp_ir[15:12]);
        check({tag, "_func"}, func, t.exp_ir[8:0]);
        m_ir  = t.exp_ir;
        m_mdr = t.exp_mdr;
    endtask

    initial begin
        vec_t r;
        int   req_seen;

        //          rd    wr    io    irw   pc      alu     wd        dly rdata     err stl req ir        mdr
        vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b1, 12'h010, 12'h000, 16'h0000, 0,  16'h8004, 0,  2,  1,  16'h8004, 16'h8004};
        vecs[1] = '{1'b0, 1'b1, 1'b1, 1'b0, 12'h010, 12'h2A0, 16'hBEEF, 5,  16'hFFFF, 0,  7,  6,  16'h8004, 16'h8004};
        vecs[2] = '{1'b1, 1'b0, 1'b1, 1'b1, 12'h055, 12'h123, 16'h0000, 2,  16'h5A5A, 0,  4,  3,  16'h8004, 16'h5A5A};
        vecs[3] = '{1'b1, 1'b0, 1'b0, 1'b0, 12'h3FF, 12'h000, 16'h0000, 14, 16'h1111, 0,  16, 15, 16'h8004, 16'h1111};
        vecs[4] = '{1'b1, 1'b0, 1'b0, 1'b1, 12'h020, 12'h000, 16'h0000, 99, 16'h7777, 16, 0,  15, 16'h0000, 16'h0000};
        vecs[5] = '{1'b1, 1'b0, 1'b0, 1'b1, 12'hFFF, 12'h000, 16'h0000, 1,  16'hF1A3, 0,  3,  2,  16'hF1A3, 16'hF1A3};
        vecs[6] = '{1'b1, 1'b1, 1'b0, 1'b1, 12'h040, 12'h041, 16'h0000, 99, 16'h0000, 1,  0,  0,  16'h0000, 16'h0000};

        // Reset state.
        set_idle();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_ir", ir, 0);
        check("rst_mdr", mdr, 0);
        check("rst_bus_req", bus_req, 0);
        check("rst_bus_we", bus_we, 0);
        check("rst_bus_err", bus_err, 0);
        check("rst_bus_addr", bus_addr, 0);
        check("rst_bus_wdata", bus_wdata, 0);
        check("rst_stall", stall, 0);

        // Directed vectors.
        for (int i = 0; i < 7; i++) begin
            verify(vecs[i], $sformatf("vec%0d", i));
        end

        // Reset during the second REQ cycle while ack and data are presented.
        r = '{1'b1, 1'b0, 1'b0, 1'b1, 12'h111, 12'h000, 16'h0000, 0, 16'hABCD, 0, 2, 1, 16'hABCD, 16'hABCD};
        verify(r, "preload");
        @(negedge clk);
        mem_read = 1'b1; iord = 1'b1; alu_out = 12'h300;
        @(negedge clk);
        #1;
        check("midrst_req_before", bus_req, 1);
        @(negedge clk);
        rst = 1'b1; bus_ack = 1'b1; bus_rdata = 16'h1234;
        @(negedge clk);
        rst = 1'b0;
        set_idle();
        #1;
        check("midrst_bus_req", bus_req, 0);
        check("midrst_mdr", mdr, 0);
        check("midrst_ir", ir, 0);
        check("midrst_stall", stall, 0);
        check("midrst_bus_addr", bus_addr, 0);
        m_ir = '0; m_mdr = '0;

        // Command held through DONE yields one transaction; later acks are ignored.
        req_seen = 0;
        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            mem_read  = (c < 3);
            iord      = 1'b0;
            ir_write  = 1'b1;
            pc        = 12'h0AA;
            bus_ack   = (c == 1) || (c >= 3 && c <= 6);
            bus_rdata = (c == 1) ? 16'h4321 : 16'hDEAD;
            #1;
            if (bus_req) req_seen++;
            if (c == 2) check("b2b_done_stall", stall, 0);
        end
        set_idle();
        check("b2b_req_cycles", req_seen, 1);
        check("b2b_mdr", mdr, 16'h4321);
        check("b2b_ir", ir, 16'h4321);
        m_ir = 16'h4321; m_mdr = 16'h4321;

        // Random transactions against the transaction-level model.
        for (int n = 0; n < 40; n++) begin
            r.pcv   = 12'($urandom);
            r.aluv  = 12'($urandom);
            r.wd    = 16'($urandom);
            r.rdata = 16'($urandom);
            r.io    = 1'($urandom);
            r.irw   = 1'($urandom);
            if ($urandom_range(0, 9) == 0) begin
                r.rd = 1'b1; r.wr = 1'b1; r.delay = 99;
                r.exp_err_cyc = 1; r.exp_req = 0; r.exp_stall = 0;
                r.exp_ir = '0; r.exp_mdr = '0;
            end else begin
                r.rd    = 1'($urandom);
                r.wr    = ~r.rd;
                r.delay = int'($urandom_range(0, TMO + 2));
                if (r.delay >= TMO) begin
                    r.exp_err_cyc = TMO + 1; r.exp_req = TMO; r.exp_stall = 0;
                    r.exp_ir = '0; r.exp_mdr = '0;
                end else begin
                    r.exp_err_cyc = 0;
                    r.exp_req     = r.delay + 1;
                    r.exp_stall   = r.delay + 2;
                    r.exp_ir      = (r.rd && !r.io && r.irw) ? r.rdata : m_ir;
                    r.exp_mdr     = r.rd ? r.rdata : m_mdr;
                end
            end
            verify(r, $sformatf("rnd%0d", n));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
